// File: rtl/dsp_vector_addsub_pipe.sv
// Pipelined signed vector add/subtract with per-lane overflow flags.
// Define DSP_VECTOR_ADDSUB_SAT_EN to saturate overflowing lanes instead of wrapping.
module dsp_vector_addsub_pipe #(
   parameter int WIDTH  = 8,
   parameter int LANES  = 4,
   parameter int STAGES = 2
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   en,
   input  logic                   in_valid,
   input  logic                   op,
   input  logic [LANES*WIDTH-1:0] a,
   input  logic [LANES*WIDTH-1:0] b,
   output logic                   out_valid,
   output logic [LANES*WIDTH-1:0] y,
   output logic [LANES-1:0]       ovf
);

   localparam int VW = LANES * WIDTH;

`ifdef DSP_VECTOR_ADDSUB_SAT_EN
   localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
`endif

   logic [VW-1:0]    s1_a;
   logic [VW-1:0]    s1_b;
   logic             s1_op;
   logic             s1_valid;

   logic [VW-1:0]    lane_y;
   logic [LANES-1:0] lane_ovf;
   logic [WIDTH:0]   ext_a;
   logic [WIDTH:0]   ext_b;
   logic [WIDTH:0]   sum;

   always_ff @(posedge clock) begin
      if (reset) begin
         s1_a     <= '0;
         s1_b     <= '0;
         s1_op    <= 1'b0;
         s1_valid <= 1'b0;
      end else if (en) begin
         s1_a     <= a;
         s1_b     <= b;
         s1_op    <= op;
         s1_valid <= in_valid;
      end
   end

   // Sign-extend to WIDTH+1; the top two result bits differ exactly on overflow.
   always_comb begin
      lane_y   = '0;
      lane_ovf = '0;
      ext_a    = '0;
      ext_b    = '0;
      sum      = '0;
      for (int i = 0; i < LANES; i++) begin
         ext_a = {s1_a[i*WIDTH+WIDTH-1], s1_a[i*WIDTH +: WIDTH]};
         ext_b = {s1_b[i*WIDTH+WIDTH-1], s1_b[i*WIDTH +: WIDTH]};
         sum   = s1_op ? (ext_a - ext_b) : (ext_a + ext_b);
         lane_ovf[i] = sum[WIDTH] ^ sum[WIDTH-1];
`ifdef DSP_VECTOR_ADDSUB_SAT_EN
         if (lane_ovf[i]) begin
            lane_y[i*WIDTH +: WIDTH] = sum[WIDTH] ? SAT_MIN : SAT_MAX;
         end else begin
            lane_y[i*WIDTH +: WIDTH] = sum[WIDTH-1:0];
         end
`else
         lane_y[i*WIDTH +: WIDTH] = sum[WIDTH-1:0];
`endif
      end
   end

   generate
      if (STAGES == 1) begin : g_one
         assign out_valid = s1_valid;
         assign y         = lane_y;
         assign ovf       = lane_ovf;
      end else begin : g_pipe
         logic [VW-1:0]    pipe_y   [STAGES-1];
         logic [LANES-1:0] pipe_ovf [STAGES-1];
         logic [STAGES-2:0] pipe_v;

         always_ff @(posedge clock) begin
            if (reset) begin
               for (int s = 0; s < STAGES-1; s++) begin
                  pipe_y[s]   <= '0;
                  pipe_ovf[s] <= '0;
               end
               pipe_v <= '0;
            end else if (en) begin
               pipe_y[0]   <= lane_y;
               pipe_ovf[0] <= lane_ovf;
               pipe_v[0]   <= s1_valid;
               for (int s = 1; s < STAGES-1; s++) begin
                  pipe_y[s]   <= pipe_y[s-1];
                  pipe_ovf[s] <= pipe_ovf[s-1];
                  pipe_v[s]   <= pipe_v[s-1];
               end
            end
         end

         assign out_valid = pipe_v[STAGES-2];
         assign y         = pipe_y[STAGES-2];
         assign ovf       = pipe_ovf[STAGES-2];
      end
   endgenerate

endmodule
